score_counter: RTL and testbench

- Producer side of the score-digit interface: maintains the running score and the high score as packed BCD digits.
- Each 4-bit digit drives one per-digit score renderer instance; the renderer is the consumer, this block is the producer.
- Advances the score from the frame tick while a game is running, captures the high score on game over, and raises a milestone pulse every 100 points (used for the score-flash effect).

---
 rtl/score_counter_pkg.sv | 13 +
 rtl/score_counter_if.sv | 33 +++
 rtl/score_counter_bcd_digit_inc.sv | 25 ++
 rtl/score_counter.sv | 152 +++++++++++++++
 tb/tb_score_counter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/score_counter_pkg.sv
// Shared definitions for the score counter: game states and BCD digit constants.
package score_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

endpackage

// File: rtl/score_counter_if.sv
// Score-digit bundle from the score counter (producer) to the per-digit renderers (consumer).
interface score_counter_if
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) ();

  logic [BCD_W*NUM_DIGITS-1:0] score_bcd;
  logic [BCD_W*NUM_DIGITS-1:0] hi_bcd;
  logic                        running;
  logic                        milestone;
  logic                        new_hi;
  logic                        saturated;

  modport master (
    output score_bcd,
    output hi_bcd,
    output running,
    output milestone,
    output new_hi,
    output saturated
  );

  modport slave (
    input score_bcd,
    input hi_bcd,
    input running,
    input milestone,
    input new_hi,
    input saturated
  );

endinterface

// File: rtl/score_counter_bcd_digit_inc.sv
// One BCD digit of the ripple incrementer: adds carry_in and wraps 9 -> 0 with carry out.
module bcd_digit_inc
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             carry_in,
  output logic [BCD_W-1:0] digit_out,
  output logic             carry_out
);

  always_comb begin
    digit_out = digit;
    carry_out = 1'b0;
    if (carry_in) begin
      // >= keeps any out-of-range code from escaping the 0..9 range
      if (digit >= BCD_MAX) begin
        digit_out = '0;
        carry_out = 1'b1;
      end else begin
        digit_out = digit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_counter.sv
// Running score / high score producer in packed BCD, paced by the frame tick,
// with game-state FSM, high-score capture and a milestone pulse every 100 points.
module score_counter
  import score_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_POINT = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_tick,
  input  logic            start,
  input  logic            die,
  score_counter_if.master sc
);

  localparam int SW = BCD_W * NUM_DIGITS;
  localparam int PW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_POINT - 1);

  state_t          r_state, w_state_nx;
  logic [SW-1:0]   r_score, w_score_nx;
  logic [SW-1:0]   r_hi, w_hi_nx;
  logic [SW-1:0]   w_inc;
  logic [PW-1:0]   r_presc, w_presc_nx;
  logic            r_milestone, w_milestone_nx;
  logic            r_new_hi, w_new_hi_nx;
  logic            r_saturated, w_saturated_nx;
  logic            r_running;
  logic            w_point;
  logic            w_score_gt;
  logic [NUM_DIGITS:0] w_carry;

  function automatic logic all_nines(input logic [SW-1:0] v);
    logic res;
    res = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*BCD_W +: BCD_W] != BCD_MAX) res = 1'b0;
    end
    return res;
  endfunction

  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_inc
    bcd_digit_inc u_digit (
      .digit     (r_score[g*BCD_W +: BCD_W]),
      .carry_in  (w_carry[g]),
      .digit_out (w_inc[g*BCD_W +: BCD_W]),
      .carry_out (w_carry[g+1])
    );
  end

  // Numeric compare, most significant differing digit decides.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_cmp
    logic gt_dig;
    logic eq_dig;
    logic gt_acc;
    assign gt_dig = r_score[g*BCD_W +: BCD_W] > r_hi[g*BCD_W +: BCD_W];
    assign eq_dig = r_score[g*BCD_W +: BCD_W] == r_hi[g*BCD_W +: BCD_W];
    if (g == 0) begin : g_lsd
      assign gt_acc = gt_dig;
    end else begin : g_upper
      assign gt_acc = gt_dig | (eq_dig & g_cmp[g-1].gt_acc);
    end
  end

  assign w_score_gt = g_cmp[NUM_DIGITS-1].gt_acc;
  assign w_point    = frame_tick && (r_presc == PRESC_LAST);

  always_comb begin
    w_state_nx     = r_state;
    w_score_nx     = r_score;
    w_hi_nx        = r_hi;
    w_presc_nx     = r_presc;
    w_milestone_nx = 1'b0;
    w_new_hi_nx    = r_new_hi;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nx = ST_RUN;
          w_score_nx = '0;
          w_presc_nx = '0;
        end
      end
      ST_RUN: begin
        if (die) begin
          w_state_nx = ST_OVER;
          if (w_score_gt) begin
            w_hi_nx     = r_score;
            w_new_hi_nx = 1'b1;
          end else begin
            w_new_hi_nx = 1'b0;
          end
        end else if (frame_tick) begin
          if (w_point) begin
            w_presc_nx = '0;
            // Final carry out means all 9s: hold instead of wrapping.
            if (!w_carry[NUM_DIGITS]) begin
              w_score_nx     = w_inc;
              w_milestone_nx = (w_inc[2*BCD_W-1:0] == '0) && (w_inc != '0);
            end
          end else begin
            w_presc_nx = r_presc + PW'(1);
          end
        end
      end
      ST_OVER: begin
        if (start) begin
          w_state_nx  = ST_RUN;
          w_score_nx  = '0;
          w_presc_nx  = '0;
          w_new_hi_nx = 1'b0;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    w_saturated_nx = all_nines(w_score_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_score     <= '0;
      r_hi        <= '0;
      r_presc     <= '0;
      r_milestone <= 1'b0;
      r_new_hi    <= 1'b0;
      r_saturated <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_score     <= w_score_nx;
      r_hi        <= w_hi_nx;
      r_presc     <= w_presc_nx;
      r_milestone <= w_milestone_nx;
      r_new_hi    <= w_new_hi_nx;
      r_saturated <= w_saturated_nx;
      r_running   <= (w_state_nx == ST_RUN);
    end
  end

  assign sc.score_bcd = r_score;
  assign sc.hi_bcd    = r_hi;
  assign sc.running   = r_running;
  assign sc.milestone = r_milestone;
  assign sc.new_hi    = r_new_hi;
  assign sc.saturated = r_saturated;

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter: a 6-ticks-per-point instance for game flow and
// a 1-tick-per-point instance for reaching saturation quickly.
module tb_score_counter;

  logic clk;
  logic rst_n, frame_tick, start, die;
  logic rst1_n, ft1, start1, die1;

  int n_chk  = 0;
  int n_fail = 0;
  int ms0_cnt = 0;
  int ms1_cnt = 0;
  logic [15:0] ms0_score = '0;
  int base;

  score_counter_if #(.NUM_DIGITS(4)) sc0 ();
  score_counter_if #(.NUM_DIGITS(4)) sc1 ();

  score_counter #(.NUM_DIGITS(4), .TICKS_PER_POINT(6)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .die(die), .sc(sc0)
  );

  score_counter #(.NUM_DIGITS(4), .TICKS_PER_POINT(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .frame_tick(ft1), .start(start1), .die(die1), .sc(sc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sc0.milestone === 1'b1) begin
      ms0_cnt++;
      ms0_score = sc0.score_bcd;
    end
    if (sc1.milestone === 1'b1) ms1_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frames0(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
    end
    frame_tick = 1'b0;
  endtask

  task automatic frames1(input int n);
    for (int i = 0; i < n; i++) begin
      ft1 = 1'b1;
      cyc();
    end
    ft1 = 1'b0;
  endtask

  task automatic pulse_start0();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_die0();
    die = 1'b1;
    cyc();
    die = 1'b0;
  endtask

  task automatic reset0();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; die = 1'b0;
    rst1_n = 1'b0; ft1 = 1'b0; start1 = 1'b0; die1 = 1'b0;
    cyc();
    cyc();
    chk("rst_score", 32'(sc0.score_bcd), 32'h0);
    chk("rst_hi", 32'(sc0.hi_bcd), 32'h0);
    chk("rst_flags", {28'h0, sc0.running, sc0.milestone, sc0.new_hi, sc0.saturated}, 32'h0);
    rst_n = 1'b1;
    cyc();
    // IDLE ignores frame_tick and die
    frames0(12);
    pulse_die0();
    chk("idle_hold", {15'h0, sc0.running, sc0.score_bcd}, 32'h0);

    pulse_start0();
    chk("start_running", 32'(sc0.running), 32'h1);
    base = ms0_cnt;
    frames0(60);
    chk("score_10", 32'(sc0.score_bcd), 32'h0010);
    chk("ms_none_60", ms0_cnt - base, 0);

    frames0(534);
    chk("score_99", 32'(sc0.score_bcd), 32'h0099);
    base = ms0_cnt;
    frames0(6);
    chk("score_100", 32'(sc0.score_bcd), 32'h0100);
    chk("ms_at_100", 32'(sc0.milestone), 32'h1);
    cyc();
    chk("ms_one_cycle", 32'(sc0.milestone), 32'h0);
    chk("ms_count_100", ms0_cnt - base, 1);
    chk("ms_aligned", 32'(ms0_score), 32'h0100);

    // Game 1/2/3 high-score capture
    reset0();
    pulse_start0();
    frames0(252);
    pulse_die0();
    chk("g1_hi", 32'(sc0.hi_bcd), 32'h0042);
    chk("g1_new_hi", 32'(sc0.new_hi), 32'h1);
    chk("g1_over", {15'h0, sc0.running, sc0.score_bcd}, 32'h0042);
    pulse_start0();
    chk("g2_clear", {14'h0, sc0.new_hi, sc0.running, sc0.score_bcd}, 32'h0001_0000);
    frames0(252);
    pulse_die0();
    chk("g2_hi", 32'(sc0.hi_bcd), 32'h0042);
    chk("g2_new_hi", 32'(sc0.new_hi), 32'h0);
    pulse_start0();
    frames0(642);
    pulse_die0();
    chk("g3_hi", 32'(sc0.hi_bcd), 32'h0107);
    chk("g3_new_hi", 32'(sc0.new_hi), 32'h1);

    // die coinciding with a point event
    pulse_start0();
    frames0(30);
    frames0(5);
    chk("pre_die_score", 32'(sc0.score_bcd), 32'h0005);
    frame_tick = 1'b1;
    die = 1'b1;
    cyc();
    frame_tick = 1'b0;
    die = 1'b0;
    chk("die_wins_score", 32'(sc0.score_bcd), 32'h0005);
    chk("die_wins_state", 32'(sc0.running), 32'h0);
    chk("die_wins_hi", {15'h0, sc0.new_hi, sc0.hi_bcd}, 32'h0000_0107);
    cyc();
    chk("over_holds", 32'(sc0.score_bcd), 32'h0005);

    // start ignored in RUN; start+die together -> OVER
    pulse_start0();
    frames0(12);
    pulse_start0();
    chk("start_ignored", {15'h0, sc0.running, sc0.score_bcd}, 32'h0001_0002);
    start = 1'b1;
    die = 1'b1;
    cyc();
    start = 1'b0;
    die = 1'b0;
    chk("start_die_over", {15'h0, sc0.running, sc0.score_bcd}, 32'h0000_0002);

    // Asynchronous reset mid-game
    reset0();
    pulse_start0();
    frames0(1200);
    pulse_die0();
    pulse_start0();
    frames0(1998);
    chk("pre_rst_score", 32'(sc0.score_bcd), 32'h0333);
    chk("pre_rst_hi", 32'(sc0.hi_bcd), 32'h0200);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_score", 32'(sc0.score_bcd), 32'h0);
    chk("async_rst_hi", 32'(sc0.hi_bcd), 32'h0);
    chk("async_rst_run", 32'(sc0.running), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    pulse_start0();
    frames0(6);
    chk("resume_score", {15'h0, sc0.running, sc0.score_bcd}, 32'h0001_0001);

    // Saturation on the 1-tick-per-point instance
    cyc();
    chk("rst1_score", {sc1.hi_bcd, sc1.score_bcd}, 32'h0);
    rst1_n = 1'b1;
    cyc();
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    base = ms1_cnt;
    frames1(9998);
    chk("sat_9998", 32'(sc1.score_bcd), 32'h9998);
    chk("sat_ms_count", ms1_cnt - base, 99);
    chk("sat_flag_pre", 32'(sc1.saturated), 32'h0);
    frames1(1);
    chk("sat_9999", 32'(sc1.score_bcd), 32'h9999);
    chk("sat_flag", {31'h0, sc1.saturated}, 32'h1);
    frames1(1);
    chk("sat_no_wrap", 32'(sc1.score_bcd), 32'h9999);
    chk("sat_no_ms", {30'h0, sc1.milestone, sc1.saturated}, 32'h1);
    chk("sat_ms_total", ms1_cnt - base, 99);
    die1 = 1'b1;
    cyc();
    die1 = 1'b0;
    chk("sat_hi", {15'h0, sc1.new_hi, sc1.hi_bcd}, 32'h0001_9999);
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    chk("sat_clear", {14'h0, sc1.saturated, sc1.running, sc1.score_bcd}, 32'h0001_0000);
    frames1(3);
    chk("t1_count", 32'(sc1.score_bcd), 32'h0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
